mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by
// mem_port_arbiter. The slave view belongs to the arbiter; the master view
// belongs to whatever drives requests and models the memory.
interface mem_port_arbiter_if #(
  parameter int MemoryWidth = 32
);
  // Fetch requester (read only)
  logic                   IReq;
  logic [MemoryWidth-1:0] IAddr;
  logic                   IRdy;
  logic [MemoryWidth-1:0] IData;

  // Data requester (read or write)
  logic                   DReq;
  logic                   DWE;
  logic [MemoryWidth-1:0] DAddr;
  logic [MemoryWidth-1:0] DWData;
  logic                   DRdy;
  logic [MemoryWidth-1:0] DRData;

  // Shared single-port memory
  logic [MemoryWidth-1:0] MemA;
  logic [MemoryWidth-1:0] MemWD;
  logic                   MemWE;
  logic [MemoryWidth-1:0] MemRD;

  modport slave (
    input  IReq, IAddr, DReq, DWE, DAddr, DWData, MemRD,
    output IRdy, IData, DRdy, DRData, MemA, MemWD, MemWE
  );

  modport master (
    output IReq, IAddr, DReq, DWE, DAddr, DWData, MemRD,
    input  IRdy, IData, DRdy, DRData, MemA, MemWD, MemWE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port. The data port is
// favoured, but the fetch port wins once it has lost MaxWait rounds in a row.
// Every grant lasts one cycle; completion is a registered one-cycle Rdy pulse
// in the cycle after the grant, which also masks a stale request from being
// granted twice.
module mem_port_arbiter #(
  parameter int MemoryWidth = 32,
  parameter int MaxWait     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic [2:0] MAX_WAIT = 3'(MaxWait);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [2:0]             wait_cnt;
  logic [2:0]             wait_cnt_nxt;
  logic                   i_elig;
  logic                   d_elig;

  logic                   i_vld_p1;
  logic                   d_vld_p1;
  logic [MemoryWidth-1:0] i_data_p1;
  logic [MemoryWidth-1:0] d_rdata_p1;

  logic [MemoryWidth-1:0] mem_a;
  logic [MemoryWidth-1:0] mem_wd;
  logic                   mem_we;

  // Saturating increment of the fetch starvation counter.
  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    if (cnt >= MAX_WAIT) begin
      return MAX_WAIT;
    end
    return cnt + 3'd1;
  endfunction

  // A requester whose Rdy is high is still showing the request just served.
  assign i_elig = bus.IReq & ~i_vld_p1;
  assign d_elig = bus.DReq & ~d_vld_p1;

  // Next-state and starvation-counter decision, made only from IDLE.
  always_comb begin
    state_nxt    = IDLE;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (i_elig && (!d_elig || wait_cnt == MAX_WAIT)) begin
          state_nxt    = GNT_I;
          wait_cnt_nxt = 3'd0;
        end else if (d_elig) begin
          state_nxt = GNT_D;
          if (i_elig) begin
            wait_cnt_nxt = sat_inc(wait_cnt);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT_I:   state_nxt = IDLE;
      GNT_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state and starvation counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // ---- stage p1: completion pulses and read data captured leaving a grant
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      i_vld_p1   <= 1'b0;
      d_vld_p1   <= 1'b0;
      i_data_p1  <= '0;
      d_rdata_p1 <= '0;
    end else begin
      i_vld_p1 <= (state == GNT_I);
      d_vld_p1 <= (state == GNT_D);
      if (state == GNT_I) begin
        i_data_p1 <= bus.MemRD;
      end
      if (state == GNT_D && !bus.DWE) begin
        d_rdata_p1 <= bus.MemRD;
      end
    end
  end

  // Memory port is a pure function of state, so an async reset into IDLE
  // drops MemWE at once and an interrupted write never commits.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    case (state)
      GNT_I: begin
        mem_a = bus.IAddr;
      end
      GNT_D: begin
        mem_a  = bus.DAddr;
        mem_wd = bus.DWData;
        mem_we = bus.DWE;
      end
      default: begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
      end
    endcase
  end

  assign bus.MemA   = mem_a;
  assign bus.MemWD  = mem_wd;
  assign bus.MemWE  = mem_we;
  assign bus.IRdy   = i_vld_p1;
  assign bus.IData  = i_data_p1;
  assign bus.DRdy   = d_vld_p1;
  assign bus.DRData = d_rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mem [0:255];
  logic         pl_en   = 1'b0;
  logic [7:0]   pl_addr = 8'd0;
  logic [W-1:0] pl_data = '0;

  mem_port_arbiter_if #(.MemoryWidth(W)) bus ();

  mem_port_arbiter #(.MemoryWidth(W), .MaxWait(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Combinational read port of the memory model.
  always_comb bus.MemRD = mem[bus.MemA[7:0]];

  // Memory writes commit on the rising edge; preload shares the same port.
  always_ff @(posedge CLK) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.MemWE) begin
      mem[bus.MemA[7:0]] <= bus.MemWD;
    end
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [W-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Contention with both requests held: fetch gets the slot in the data Rdy cycle.
  logic [W-1:0] con_a  [8] = '{32'h0, 32'h20, 32'h0, 32'h10, 32'h0, 32'h20, 32'h0, 32'h10};
  logic [1:0]   con_rd [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  // Starvation: IReq present only in rounds where both are eligible -> D,D,D,I.
  logic [12:0]  stv_i = 13'b0_0110_0100_1001;
  logic [W-1:0] stv_a [13] = '{32'h0, 32'h20, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0,
                               32'h20, 32'h0, 32'h0, 32'h10, 32'h0, 32'h20};

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.IReq   = 1'b0;
    bus.IAddr  = '0;
    bus.DReq   = 1'b0;
    bus.DWE    = 1'b0;
    bus.DAddr  = '0;
    bus.DWData = '0;

    // Reset before any clock edge
    #1 RST = 1'b0;
    #2;
    check_val("rst_irdy",   32'(bus.IRdy),  32'h0);
    check_val("rst_drdy",   32'(bus.DRdy),  32'h0);
    check_val("rst_idata",  bus.IData,      32'h0);
    check_val("rst_drdata", bus.DRData,     32'h0);
    check_val("rst_mema",   bus.MemA,       32'h0);
    check_val("rst_memwd",  bus.MemWD,      32'h0);
    check_val("rst_memwe",  32'(bus.MemWE), 32'h0);

    preload(8'd5,    32'hDEADBEEF);
    preload(8'h30,   32'hAAAA5555);
    preload(8'h10,   32'h600DCAFE);
    preload(8'h20,   32'h0BADF00D);
    #3 RST = 1'b1;
    tick();

    // Fetch only
    bus.IReq  = 1'b1;
    bus.IAddr = 32'd5;
    check_val("fetch_idle_mema", bus.MemA, 32'h0);
    tick();
    check_val("fetch_gnt_mema",  bus.MemA,       32'd5);
    check_val("fetch_gnt_memwe", 32'(bus.MemWE), 32'h0);
    check_val("fetch_gnt_irdy",  32'(bus.IRdy),  32'h0);
    tick();
    check_val("fetch_irdy",      32'(bus.IRdy),  32'h1);
    check_val("fetch_idata",     bus.IData,      32'hDEADBEEF);
    check_val("fetch_rdy_mema",  bus.MemA,       32'h0);
    bus.IReq = 1'b0;
    tick();
    check_val("fetch_irdy_end",  32'(bus.IRdy),  32'h0);

    // Data write then read back
    bus.DReq   = 1'b1;
    bus.DWE    = 1'b1;
    bus.DAddr  = 32'd101;
    bus.DWData = 32'h12345678;
    tick();
    check_val("wr_gnt_memwe", 32'(bus.MemWE), 32'h1);
    check_val("wr_gnt_mema",  bus.MemA,       32'd101);
    check_val("wr_gnt_memwd", bus.MemWD,      32'h12345678);
    tick();
    check_val("wr_drdy",      32'(bus.DRdy),  32'h1);
    check_val("wr_drdata",    bus.DRData,     32'h0);
    check_val("wr_memwe_off", 32'(bus.MemWE), 32'h0);
    check_val("wr_mem101",    mem[8'd101],    32'h12345678);
    bus.DReq = 1'b0;
    bus.DWE  = 1'b0;
    tick();
    check_val("wr_drdy_end",  32'(bus.DRdy),  32'h0);
    bus.DReq = 1'b1;
    tick();
    check_val("rd_gnt_memwe", 32'(bus.MemWE), 32'h0);
    check_val("rd_gnt_mema",  bus.MemA,       32'd101);
    tick();
    check_val("rd_drdy",      32'(bus.DRdy),  32'h1);
    check_val("rd_drdata",    bus.DRData,     32'h12345678);
    bus.DReq = 1'b0;
    tick();

    // Stale fetch request held through its Rdy cycle, nothing else pending
    bus.IReq  = 1'b1;
    bus.IAddr = 32'd7;
    tick();
    tick();
    check_val("stale_irdy",      32'(bus.IRdy), 32'h1);
    tick();
    check_val("stale_no_regrant", bus.MemA,     32'h0);
    check_val("stale_irdy_end",  32'(bus.IRdy), 32'h0);
    bus.IReq = 1'b0;
    tick();

    // Stale fetch request with a data request pending
    bus.IReq  = 1'b1;
    bus.IAddr = 32'd7;
    tick();
    bus.DReq  = 1'b1;
    bus.DWE   = 1'b0;
    bus.DAddr = 32'h20;
    tick();
    check_val("stale2_irdy",   32'(bus.IRdy), 32'h1);
    tick();
    check_val("stale2_gnt_d",  bus.MemA,      32'h20);
    bus.IReq = 1'b0;
    tick();
    check_val("stale2_drdy",   32'(bus.DRdy), 32'h1);
    check_val("stale2_drdata", bus.DRData,    32'h0BADF00D);
    bus.DReq = 1'b0;
    tick();

    // Contention, both requests held continuously
    bus.IReq  = 1'b1;
    bus.IAddr = 32'h10;
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("con_mema_%0d", k), bus.MemA, con_a[k]);
      check_val($sformatf("con_rdy_%0d", k), 32'({bus.IRdy, bus.DRdy}), 32'(con_rd[k]));
      tick();
    end
    check_val("con_idata", bus.IData, 32'h600DCAFE);
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    tick();

    // Fetch starvation limit (MaxWait=3)
    bus.DReq = 1'b1;
    for (int k = 0; k < 13; k++) begin
      bus.IReq = stv_i[k];
      check_val($sformatf("stv_mema_%0d", k), bus.MemA, stv_a[k]);
      tick();
    end
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    tick();
    tick();

    // Idle port
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("idle_mema_%0d", k),  bus.MemA,  32'h0);
      check_val($sformatf("idle_memwd_%0d", k), bus.MemWD, 32'h0);
      check_val($sformatf("idle_ctl_%0d", k),
                32'({bus.MemWE, bus.IRdy, bus.DRdy}), 32'h0);
      tick();
    end

    // Reset in the middle of a write grant
    bus.DReq   = 1'b1;
    bus.DWE    = 1'b1;
    bus.DAddr  = 32'h30;
    bus.DWData = 32'h11112222;
    tick();
    check_val("mrst_gnt_memwe", 32'(bus.MemWE), 32'h1);
    #3 RST = 1'b0;
    #1;
    check_val("mrst_memwe",  32'(bus.MemWE), 32'h0);
    check_val("mrst_mema",   bus.MemA,       32'h0);
    check_val("mrst_memwd",  bus.MemWD,      32'h0);
    check_val("mrst_idata",  bus.IData,      32'h0);
    check_val("mrst_drdata", bus.DRData,     32'h0);
    bus.DReq = 1'b0;
    bus.DWE  = 1'b0;
    tick();
    check_val("mrst_mem30",  mem[8'h30],     32'hAAAA5555);
    check_val("mrst_drdy",   32'(bus.DRdy),  32'h0);
    #3 RST = 1'b1;
    tick();
    check_val("mrst_rel_drdy", 32'(bus.DRdy), 32'h0);
    check_val("mrst_rel_mema", bus.MemA,      32'h0);
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h30;
    tick();
    check_val("mrst_resume_mema", bus.MemA,     32'h30);
    tick();
    check_val("mrst_resume_drdy", 32'(bus.DRdy), 32'h1);
    check_val("mrst_resume_data", bus.DRData,   32'hAAAA5555);
    bus.DReq = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
